pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush of the PC,
//  IF_ID, ID_EX, EX_MEM and MEM_WB registers from hazard inputs: load-use, branch redirect,

---
 rtl/pipeline_ctrl_pkg.sv | 58 +++++
 rtl/mdu_busy_counter.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - ctrl_state_e : debug/perf encoding of the case applied this cycle
//   - pipe_ctrl_t  : bundle of the per-register enable/flush controls
//   - default MUL/DIV latencies and the MDU counter width helper
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MDU_WAIT   = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_ena;
    logic if_id_ena;
    logic if_id_flush;
    logic id_ex_ena;
    logic id_ex_flush;
    logic ex_mem_ena;
    logic mem_wb_ena;
  } pipe_ctrl_t;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 32;
  localparam int unsigned MDU_CNT_W_DEF  = $clog2(DIV_CYCLES_DEF);

  // Bits needed to hold the largest preload value (latency - 1).
  function automatic int unsigned mdu_cnt_width(input int unsigned div_cycles,
                                                input int unsigned mul_cycles);
    int unsigned m;
    m = (div_cycles > mul_cycles) ? div_cycles : mul_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Control patterns for each case.
  localparam pipe_ctrl_t CTRL_RUN = '{pc_ena: 1'b1, if_id_ena: 1'b1, if_id_flush: 1'b0,
                                      id_ex_ena: 1'b1, id_ex_flush: 1'b0,
                                      ex_mem_ena: 1'b1, mem_wb_ena: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_ena: 1'b0, if_id_ena: 1'b0, if_id_flush: 1'b0,
                                         id_ex_ena: 1'b0, id_ex_flush: 1'b0,
                                         ex_mem_ena: 1'b0, mem_wb_ena: 1'b0};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_ena: 1'b1, if_id_ena: 1'b1, if_id_flush: 1'b1,
                                           id_ex_ena: 1'b1, id_ex_flush: 1'b1,
                                           ex_mem_ena: 1'b1, mem_wb_ena: 1'b1};
  // Hold PC and IF_ID, inject a bubble into ID_EX, let the back end drain.
  localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_ena: 1'b0, if_id_ena: 1'b0, if_id_flush: 1'b0,
                                         id_ex_ena: 1'b1, id_ex_flush: 1'b1,
                                         ex_mem_ena: 1'b1, mem_wb_ena: 1'b1};
  // Fetch word not valid: hold PC, put a NOP into IF_ID, everything behind advances.
  localparam pipe_ctrl_t CTRL_IMEM_WAIT = '{pc_ena: 1'b0, if_id_ena: 1'b1, if_id_flush: 1'b1,
                                            id_ex_ena: 1'b1, id_ex_flush: 1'b0,
                                            ex_mem_ena: 1'b1, mem_wb_ena: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET = '{pc_ena: 1'b0, if_id_ena: 1'b0, if_id_flush: 1'b1,
                                        id_ex_ena: 1'b0, id_ex_flush: 1'b1,
                                        ex_mem_ena: 1'b0, mem_wb_ena: 1'b0};

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks MUL/DIV occupancy of the multi-cycle divide/multiply unit.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   load         : start accepted this cycle (already qualified by the top)
//   is_div       : 1 = divide latency, 0 = multiply latency
//   busy         : result not yet available (counter != 0)
module mdu_busy_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = mdu_cnt_width(DIV_CYCLES, MUL_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  // The start cycle itself counts as the first busy cycle, hence latency - 1.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset; reset mid-operation simply discards the pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   i_ID_*                  : source-register usage and MDU use of the ID instruction
//   i_EX_*                  : destination/load/MDU-start/branch info of the EX instruction
//   i_imem_ready/dmem_ready : fetch word valid / MEM-stage access complete
//   o_*_ena / o_*_flush     : pipeline register enables and synchronous NOP clears
//   o_mdu_busy              : MDU result not yet available
//   o_state                 : which case applied this cycle (debug/perf)
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_ID_rs,
  input  logic [REG_AW-1:0] i_ID_rt,
  input  logic              i_ID_uses_rs,
  input  logic              i_ID_uses_rt,
  input  logic              i_ID_mdu_op,
  input  logic [REG_AW-1:0] i_EX_wreg_addr,
  input  logic              i_EX_wreg_ena,
  input  logic              i_EX_is_load,
  input  logic              i_EX_mdu_start,
  input  logic              i_EX_mdu_is_div,
  input  logic              i_EX_branch_taken,
  input  logic              i_imem_ready,
  input  logic              i_dmem_ready,
  output logic              o_pc_ena,
  output logic              o_IF_ID_ena,
  output logic              o_IF_ID_flush,
  output logic              o_ID_EX_ena,
  output logic              o_ID_EX_flush,
  output logic              o_EX_MEM_ena,
  output logic              o_MEM_WB_ena,
  output logic              o_mdu_busy,
  output logic [1:0]        o_state
);

  logic        load_use;
  logic        mdu_hazard;
  logic        mdu_load;
  pipe_ctrl_t  ctrl;
  ctrl_state_e state;

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = i_EX_is_load && i_EX_wreg_ena && (i_EX_wreg_addr != '0) &&
                    ((i_ID_uses_rs && (i_EX_wreg_addr == i_ID_rs)) ||
                     (i_ID_uses_rt && (i_EX_wreg_addr == i_ID_rt)));

  assign mdu_hazard = i_ID_mdu_op && (o_mdu_busy || i_EX_mdu_start);

  // A start seen while frozen or being squashed is not taken; during a
  // freeze it stays in EX and is accepted once the freeze ends.
  assign mdu_load = i_EX_mdu_start && i_dmem_ready && !i_EX_branch_taken;

  mdu_busy_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (mdu_load),
    .is_div (i_EX_mdu_is_div),
    .busy   (o_mdu_busy)
  );

  // Priority encoder: exactly one case applies per cycle.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl  = CTRL_RUN;
    state = ST_RUN;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (!i_dmem_ready) begin
      // Whole pipe frozen; a taken branch stays in EX and redirects afterwards.
      ctrl  = CTRL_FREEZE;
      state = ST_MEM_WAIT;
    end else if (i_EX_branch_taken) begin
      ctrl = CTRL_REDIRECT;
    end else if (load_use) begin
      // One bubble suffices: MEM forwarding covers the following cycle.
      ctrl  = CTRL_BUBBLE;
      state = ST_LOAD_STALL;
    end else if (mdu_hazard) begin
      ctrl  = CTRL_BUBBLE;
      state = ST_MDU_WAIT;
    end else if (!i_imem_ready) begin
      ctrl = CTRL_IMEM_WAIT;
    end
  end

  assign o_pc_ena      = ctrl.pc_ena;
  assign o_IF_ID_ena   = ctrl.if_id_ena;
  assign o_IF_ID_flush = ctrl.if_id_flush;
  assign o_ID_EX_ena   = ctrl.id_ex_ena;
  assign o_ID_EX_flush = ctrl.id_ex_flush;
  assign o_EX_MEM_ena  = ctrl.ex_mem_ena;
  assign o_MEM_WB_ena  = ctrl.mem_wb_ena;
  assign o_state       = state;

endmodule
